// File: rtl/mvm_noc_pkg.sv
// Shared NoC types for MVM injectors: widths, RF-write tuser layout, FSM states.
package mvm_noc_pkg;

  localparam int unsigned DATAW      = 512;
  localparam int unsigned USERW      = 76;
  localparam int unsigned DESTW      = 12;
  localparam int unsigned ADDRW      = 9;
  localparam int unsigned OPW        = 2;
  localparam int unsigned NUM_RF     = 64;
  localparam int unsigned RFW        = 7;   // holds 1..NUM_RF
  localparam int unsigned RF_IDXW    = 6;   // holds 0..NUM_RF-1
  localparam int unsigned BEATW      = 16;  // holds rows*rfs-1 up to 512*64-1
  localparam int unsigned ADDR_LSB   = 0;
  localparam int unsigned OP_LSB     = 9;
  localparam int unsigned RF_SEL_LSB = 11;

  typedef enum logic [OPW-1:0] {
    OP_RSVD0 = 2'b00,
    OP_RSVD1 = 2'b01,
    OP_RSVD2 = 2'b10,
    OP_WR_RF = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [DESTW-1:0] dest;
    logic [USERW-1:0] user;
    logic [DATAW-1:0] data;
  } axis_beat_t;

  typedef struct packed {
    logic [ADDRW-1:0] base;
    logic [ADDRW:0]   rows;
    logic [RFW-1:0]   rfs;
    logic [DESTW-1:0] dest;
  } job_cfg_t;

  // RF-write sideband: row address, opcode, one-hot RF select, everything else zero.
  function automatic logic [USERW-1:0] build_rf_tuser(input logic [ADDRW-1:0]   row,
                                                      input logic [RF_IDXW-1:0] rf_idx);
    logic [USERW-1:0] u;
    u = '0;
    u[ADDR_LSB +: ADDRW] = row;
    u[OP_LSB +: OPW]     = OP_WR_RF;
    u = u | (USERW'(1) << (RF_SEL_LSB + 32'(rf_idx)));
    return u;
  endfunction

endpackage

// File: rtl/mvm_rf_weight_loader_if.sv
// Weight-word input stream and NoC AXI-stream injection port of the RF weight loader.
interface mvm_rf_weight_loader_if;
  import mvm_noc_pkg::*;

  logic             s_valid;
  logic             s_ready;
  logic [DATAW-1:0] s_data;

  logic             axis_m_tvalid;
  logic             axis_m_tready;
  logic [DATAW-1:0] axis_m_tdata;
  logic             axis_m_tlast;
  logic [USERW-1:0] axis_m_tuser;
  logic [DESTW-1:0] axis_m_tdest;

  modport master (
    input  s_valid, s_data, axis_m_tready,
    output s_ready, axis_m_tvalid, axis_m_tdata, axis_m_tlast, axis_m_tuser, axis_m_tdest
  );

  modport slave (
    output s_valid, s_data, axis_m_tready,
    input  s_ready, axis_m_tvalid, axis_m_tdata, axis_m_tlast, axis_m_tuser, axis_m_tdest
  );
endinterface

// File: rtl/mvm_axis_out_reg.sv
// Single-entry AXI-stream output register; refills in the same cycle the held beat drains.
module mvm_axis_out_reg
  import mvm_noc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  axis_beat_t       load_beat,
  output logic             can_load_c,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [DATAW-1:0] m_tdata,
  output logic [USERW-1:0] m_tuser,
  output logic [DESTW-1:0] m_tdest,
  output logic             m_tlast
);

  axis_beat_t beat_q;

  assign can_load_c = !m_tvalid || m_tready;

  // Payload only moves on load, which the owner issues only when can_load_c is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      beat_q   <= '0;
    end else if (load) begin
      m_tvalid <= 1'b1;
      m_tlast  <= 1'b1;
      beat_q   <= load_beat;
    end else if (m_tready) begin
      m_tvalid <= 1'b0;
    end
  end

  assign m_tdata = beat_q.data;
  assign m_tuser = beat_q.user;
  assign m_tdest = beat_q.dest;

endmodule

// File: rtl/mvm_rf_weight_loader.sv
// Streams weight words into MVM register files as single-beat RF-write NoC packets,
// row-major over the job with the RF index as the inner loop.
module mvm_rf_weight_loader
  import mvm_noc_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [ADDRW-1:0]      cfg_base_addr,
  input  logic [ADDRW:0]        cfg_num_rows,
  input  logic [RFW-1:0]        cfg_num_rfs,
  input  logic [DESTW-1:0]      cfg_dest,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  mvm_rf_weight_loader_if.master bus
);

  state_e               state, state_nxt;
  job_cfg_t             job, job_nxt;
  logic [BEATW-1:0]     beat_cnt, beat_cnt_nxt;
  logic [RF_IDXW-1:0]   rf_idx, rf_idx_nxt;
  logic [ADDRW-1:0]     row_off, row_off_nxt;
  logic                 busy_nxt, done_nxt, err_nxt;
  logic                 cfg_ok_c, can_load_c, s_ready_c, accept_c, last_word_c;
  logic [BEATW-1:0]     last_idx_c;
  logic [ADDRW-1:0]     row_c;
  axis_beat_t           beat_c;

  assign cfg_ok_c    = (cfg_num_rows != '0) && (cfg_num_rfs != '0) &&
                       (cfg_num_rfs <= RFW'(NUM_RF));
  assign s_ready_c   = (state == RUN) && can_load_c;
  assign bus.s_ready = s_ready_c;
  assign accept_c    = bus.s_valid && s_ready_c;
  assign last_idx_c  = BEATW'(job.rows) * BEATW'(job.rfs) - BEATW'(1);
  assign last_word_c = (beat_cnt == last_idx_c);
  assign row_c       = job.base + row_off;  // natural 9-bit wrap 511 -> 0
  assign beat_c      = '{dest: job.dest, user: build_rf_tuser(row_c, rf_idx), data: bus.s_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      job      <= '0;
      beat_cnt <= '0;
      rf_idx   <= '0;
      row_off  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      job      <= job_nxt;
      beat_cnt <= beat_cnt_nxt;
      rf_idx   <= rf_idx_nxt;
      row_off  <= row_off_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    job_nxt      = job;
    beat_cnt_nxt = beat_cnt;
    rf_idx_nxt   = rf_idx;
    row_off_nxt  = row_off;
    done_nxt     = 1'b0;
    err_nxt      = 1'b0;

    unique case (state)
      IDLE: begin
        if (cfg_start) begin
          if (!cfg_ok_c) begin
            err_nxt = 1'b1;
          end else begin
            job_nxt      = '{base: cfg_base_addr, rows: cfg_num_rows,
                             rfs: cfg_num_rfs, dest: cfg_dest};
            beat_cnt_nxt = '0;
            rf_idx_nxt   = '0;
            row_off_nxt  = '0;
            state_nxt    = RUN;
          end
        end
      end
      RUN: begin
        if (accept_c) begin
          if (last_word_c) begin
            state_nxt = DRAIN;
          end else begin
            beat_cnt_nxt = beat_cnt + BEATW'(1);
            // RF index is the inner loop; its wrap advances the row.
            if (RFW'(rf_idx) == job.rfs - RFW'(1)) begin
              rf_idx_nxt  = '0;
              row_off_nxt = row_off + ADDRW'(1);
            end else begin
              rf_idx_nxt  = rf_idx + RF_IDXW'(1);
            end
          end
        end
      end
      DRAIN: begin
        if (bus.axis_m_tvalid && bus.axis_m_tready) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  mvm_axis_out_reg u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (accept_c),
    .load_beat  (beat_c),
    .can_load_c (can_load_c),
    .m_tvalid   (bus.axis_m_tvalid),
    .m_tready   (bus.axis_m_tready),
    .m_tdata    (bus.axis_m_tdata),
    .m_tuser    (bus.axis_m_tuser),
    .m_tdest    (bus.axis_m_tdest),
    .m_tlast    (bus.axis_m_tlast)
  );

endmodule

// File: tb/tb_mvm_rf_weight_loader.sv
// Randomized bench for mvm_rf_weight_loader against a job-level beat model.
module tb_mvm_rf_weight_loader;

  logic        clk;
  logic        rst;
  logic        cfg_start;
  logic [8:0]  cfg_base_addr;
  logic [9:0]  cfg_num_rows;
  logic [6:0]  cfg_num_rfs;
  logic [11:0] cfg_dest;
  logic        busy, done, err;

  int n_cmp = 0;
  int n_bad = 0;

  mvm_rf_weight_loader_if bus ();

  mvm_rf_weight_loader dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_start     (cfg_start),
    .cfg_base_addr (cfg_base_addr),
    .cfg_num_rows  (cfg_num_rows),
    .cfg_num_rfs   (cfg_num_rfs),
    .cfg_dest      (cfg_dest),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Beat i: RF (i mod rfs) at row (base + i div rfs) mod 512, opcode 3, one-hot select from bit 11.
  function automatic logic [75:0] exp_user(input int i, input logic [8:0] base, input logic [6:0] rfs);
    logic [75:0] u;
    int rf;
    int row;
    rf  = i % int'(rfs);
    row = (int'(base) + i / int'(rfs)) % 512;
    u = '0;
    u[8:0]  = 9'(row);
    u[10:9] = 2'b11;
    u = u | (76'(1) << (11 + rf));
    return u;
  endfunction

  // Called just after a rising edge; returns just after the edge where DONE is seen
  // (or after the stop_after-th output beat when stop_after >= 0).
  task automatic run_job(input logic [8:0] base, input logic [9:0] rows, input logic [6:0] rfs,
                         input logic [11:0] dest, input int tr_pct, input int sv_pct,
                         input int stop_after, input int inj_at, input bit chk_rate);
    int           total = int'(rows) * int'(rfs);
    int           in_cnt = 0;
    int           out_cnt = 0;
    int           iter = 0;
    int           first_hs = -1;
    int           last_hs = -1;
    bit           stall = 0;
    bit           hs_last = 0;
    bit           fin = 0;
    logic         exp_rdy, ohs, acc, tv, tl;
    logic [511:0] cur, td, p_data;
    logic [75:0]  tu, p_user;
    logic [11:0]  tdst, p_dest;
    logic [511:0] sent_q[$];

    cur = rnd512();
    p_data = '0; p_user = '0; p_dest = '0;
    cfg_start = 1'b1; cfg_base_addr = base; cfg_num_rows = rows;
    cfg_num_rfs = rfs; cfg_dest = dest;

    while (iter < 20000) begin
      tv = bus.axis_m_tvalid; td = bus.axis_m_tdata; tu = bus.axis_m_tuser;
      tdst = bus.axis_m_tdest; tl = bus.axis_m_tlast;
      if (iter > 0) begin
        n_cmp++;
        if (hs_last) begin
          if (done !== 1'b1 || busy !== 1'b0) begin
            n_bad++; $display("FAIL done_pulse: done=%b busy=%b want done=1 busy=0", done, busy);
          end
          fin = 1;
        end else if (done !== 1'b0 || busy !== 1'b1) begin
          n_bad++; $display("FAIL busy_mid_job iter %0d: done=%b busy=%b want done=0 busy=1", iter, done, busy);
        end
        n_cmp++;
        if (err !== 1'b0) begin
          n_bad++; $display("FAIL err_mid_job iter %0d: err=%b want 0", iter, err);
        end
      end
      if (stall) begin
        n_cmp++;
        if (tv !== 1'b1 || td !== p_data || tu !== p_user || tdst !== p_dest) begin
          n_bad++; $display("FAIL stall_hold iter %0d: tvalid=%b tuser=%h tdest=%h want tvalid=1 tuser=%h tdest=%h",
                            iter, tv, tu, tdst, p_user, p_dest);
        end
      end
      if (fin || (stop_after >= 0 && out_cnt == stop_after)) break;

      if (iter > 0) begin
        cfg_start = (iter == inj_at);
        if (iter == inj_at) begin
          cfg_base_addr = 9'd300; cfg_num_rows = 10'd1; cfg_num_rfs = 7'd1; cfg_dest = 12'hFFF;
        end
      end
      bus.axis_m_tready = ($urandom_range(99) < tr_pct);
      bus.s_valid = (in_cnt < total) && ($urandom_range(99) < sv_pct);
      bus.s_data = cur;
      #1;
      exp_rdy = (iter > 0) && (in_cnt < total) && (!tv || bus.axis_m_tready);
      n_cmp++;
      if (bus.s_ready !== exp_rdy) begin
        n_bad++; $display("FAIL s_ready iter %0d: got %b want %b", iter, bus.s_ready, exp_rdy);
      end
      ohs = tv && bus.axis_m_tready;
      acc = bus.s_valid && bus.s_ready;
      if (ohs) begin
        n_cmp++;
        if (out_cnt >= total || out_cnt >= sent_q.size()) begin
          n_bad++; $display("FAIL extra_beat: beat %0d seen, job has %0d", out_cnt, total);
        end else if (td !== sent_q[out_cnt] || tu !== exp_user(out_cnt, base, rfs) ||
                     tdst !== dest || tl !== 1'b1) begin
          n_bad++; $display("FAIL beat %0d: tuser=%h tdest=%h tlast=%b data_ok=%b want tuser=%h tdest=%h tlast=1",
                            out_cnt, tu, tdst, tl, td === sent_q[out_cnt], exp_user(out_cnt, base, rfs), dest);
        end
        if (first_hs < 0) first_hs = iter;
        last_hs = iter;
        out_cnt++;
      end
      hs_last = ohs && (out_cnt == total);
      stall = tv && !bus.axis_m_tready;
      p_data = td; p_user = tu; p_dest = tdst;
      if (acc) begin
        sent_q.push_back(cur);
        in_cnt++;
        cur = rnd512();
      end
      @(posedge clk); #1;
      iter++;
    end

    cfg_start = 1'b0;
    bus.s_valid = 1'b0;
    if (!fin && !(stop_after >= 0 && out_cnt == stop_after)) begin
      n_cmp++; n_bad++;
      $display("FAIL job_timeout: %0d of %0d beats after %0d cycles", out_cnt, total, iter);
    end
    if (fin && chk_rate) begin
      n_cmp++;
      if (first_hs != 2 || last_hs - first_hs != total - 1) begin
        n_bad++; $display("FAIL full_rate: first beat at %0d span %0d want 2 span %0d",
                          first_hs, last_hs - first_hs, total - 1);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if ({bus.axis_m_tvalid, bus.axis_m_tlast, busy, done, err, bus.s_ready} !== 6'b0 ||
        bus.axis_m_tdata !== '0 || bus.axis_m_tuser !== '0 || bus.axis_m_tdest !== '0) begin
      n_bad++; $display("FAIL %s: tvalid=%b tlast=%b busy=%b done=%b err=%b s_ready=%b tuser=%h tdest=%h want all 0",
                        tag, bus.axis_m_tvalid, bus.axis_m_tlast, busy, done, err, bus.s_ready,
                        bus.axis_m_tuser, bus.axis_m_tdest);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_base_job();
    run_job(9'd1, 10'd1, 7'd64, 12'hA5C, 100, 100, -1, -1, 1);
  endtask

  task automatic test_row_wrap();
    run_job(9'd510, 10'd3, 7'd2, 12'h3F0, 100, 100, -1, -1, 1);
  endtask

  task automatic test_backpressure();
    run_job(9'd100, 10'd4, 7'd4, 12'h123, 50, 100, -1, -1, 0);
    run_job(9'd257, 10'd4, 7'd4, 12'h456, 50, 70, -1, -1, 0);
  endtask

  task automatic test_illegal_cfg();
    logic [9:0] bad_rows[3];
    logic [6:0] bad_rfs[3];
    bad_rows[0] = 10'd1; bad_rfs[0] = 7'd0;
    bad_rows[1] = 10'd1; bad_rfs[1] = 7'd65;
    bad_rows[2] = 10'd0; bad_rfs[2] = 7'd4;
    for (int k = 0; k < 3; k++) begin
      cfg_start = 1'b1; cfg_base_addr = 9'd5; cfg_num_rows = bad_rows[k];
      cfg_num_rfs = bad_rfs[k]; cfg_dest = 12'h0AA;
      bus.s_valid = 1'b1; bus.axis_m_tready = 1'b1;
      @(posedge clk); #1;
      cfg_start = 1'b0;
      #1;
      n_cmp++;
      if (err !== 1'b1 || busy !== 1'b0 || bus.s_ready !== 1'b0) begin
        n_bad++; $display("FAIL illegal_cfg %0d: err=%b busy=%b s_ready=%b want 1 0 0", k, err, busy, bus.s_ready);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (err !== 1'b0 || busy !== 1'b0 || bus.s_ready !== 1'b0 || bus.axis_m_tvalid !== 1'b0) begin
        n_bad++; $display("FAIL illegal_after %0d: err=%b busy=%b s_ready=%b tvalid=%b want all 0",
                          k, err, busy, bus.s_ready, bus.axis_m_tvalid);
      end
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic test_start_while_busy();
    run_job(9'd7, 10'd3, 7'd5, 12'h0BB, 80, 90, -1, 6, 0);
  endtask

  task automatic test_reset_mid_job();
    run_job(9'd0, 10'd4, 7'd4, 12'h5A5, 100, 100, 5, -1, 0);
    bus.axis_m_tready = 1'b0;
    bus.s_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_all_zero("reset_mid_job");
    rst = 1'b0;
    bus.axis_m_tready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || bus.axis_m_tvalid !== 1'b0 || bus.s_ready !== 1'b0) begin
        n_bad++; $display("FAIL after_reset %0d: done=%b busy=%b tvalid=%b s_ready=%b want all 0",
                          c, done, busy, bus.axis_m_tvalid, bus.s_ready);
      end
    end
    bus.s_valid = 1'b0;
    run_job(9'd40, 10'd2, 7'd3, 12'h777, 100, 100, -1, -1, 1);
  endtask

  task automatic test_back_to_back();
    run_job(9'd20, 10'd2, 7'd3, 12'h111, 100, 100, -1, -1, 1);
    run_job(9'd480, 10'd2, 7'd2, 12'h222, 100, 100, -1, -1, 1);
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 4; j++) begin
      run_job(9'($urandom_range(511)), 10'($urandom_range(6, 1)), 7'($urandom_range(8, 1)),
              12'($urandom), $urandom_range(100, 30), $urandom_range(100, 30), -1, -1, 0);
    end
  endtask

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0; cfg_base_addr = '0; cfg_num_rows = '0; cfg_num_rfs = '0; cfg_dest = '0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.axis_m_tready = 1'b0;
    test_reset();
    test_base_job();
    test_row_wrap();
    test_backpressure();
    test_illegal_cfg();
    test_start_while_busy();
    test_reset_mid_job();
    test_back_to_back();
    test_random_jobs();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
